pdm_encoder: RTL and testbench



---
 rtl/pdm_pkg.sv | 18 +
 rtl/pdm_sd_mod.sv | 38 +++
 rtl/pdm_encoder.sv | 86 ++++++++
 tb/tb_pdm_encoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants, sample-pair type and level clamp for the PDM encoder/decoder pair.
package pdm_pkg;

  localparam int FRAME_BITS     = 14;
  localparam int DATA_W         = 16;
  localparam int PDM_FULL_SCALE = 1 << FRAME_BITS;

  typedef struct packed {
    logic [DATA_W-1:0] lft;
    logic [DATA_W-1:0] rght;
  } pdm_pair_t;

  // Levels beyond one frame's worth of ones saturate at full scale.
  function automatic int clamp_level(input int level, input int full_scale);
    return (level > full_scale) ? full_scale : level;
  endfunction

endpackage

// File: rtl/pdm_sd_mod.sv
// One-channel first-order sigma-delta modulator: clamp, phase-continuous accumulator, registered bit.
module pdm_sd_mod
  import pdm_pkg::*;
#(
  parameter int FRAME_BITS = pdm_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] level_i,
  output logic              pdm_o
);

  localparam int FULL = 1 << FRAME_BITS;

  logic [FRAME_BITS:0] level_c;
  logic [FRAME_BITS:0] acc_q;
  logic [FRAME_BITS:0] acc_d;
  logic                pdm_q;

  // The carry out of the fractional part is the output bit; the accumulator is never cleared.
  always_comb begin
    level_c = (FRAME_BITS+1)'(clamp_level(int'(level_i), FULL));
    acc_d   = {1'b0, acc_q[FRAME_BITS-1:0]} + level_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= acc_d[FRAME_BITS];
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/pdm_encoder.sv
// Dual-channel PDM encoder: one-deep pending buffer, frame counter and per-channel modulators.
module pdm_encoder
  import pdm_pkg::*;
#(
  parameter int FRAME_BITS = pdm_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  input  logic [DATA_W-1:0] lft_pcm,
  input  logic [DATA_W-1:0] rght_pcm,
  output logic              lft_PDM,
  output logic              rght_PDM,
  output logic              frame_strt,
  output logic              underrun
);

  logic [FRAME_BITS-1:0] cnt_q, cnt_d;
  logic                  pend_full_q, pend_full_d;
  pdm_pair_t             pend_q, pend_d;
  pdm_pair_t             act_q, act_d;
  logic                  strt_q, strt_d;
  logic                  under_q, under_d;
  logic                  boundary;
  logic                  accept;

  assign boundary = &cnt_q;
  assign accept   = smpl_vld && !pend_full_q;

  // No bypass: a pair accepted in the boundary cycle waits in pending for a whole frame.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    act_d       = act_q;
    strt_d      = boundary;
    under_d     = boundary && !pend_full_q;
    if (boundary && pend_full_q) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d.lft  = lft_pcm;
      pend_d.rght = rght_pcm;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
      strt_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      strt_q      <= strt_d;
      under_q     <= under_d;
    end
  end

  pdm_sd_mod #(.FRAME_BITS(FRAME_BITS)) u_mod_lft (
    .clk    (clk),
    .rst    (rst),
    .level_i(act_q.lft),
    .pdm_o  (lft_PDM)
  );

  pdm_sd_mod #(.FRAME_BITS(FRAME_BITS)) u_mod_rght (
    .clk    (clk),
    .rst    (rst),
    .level_i(act_q.rght),
    .pdm_o  (rght_PDM)
  );

  assign smpl_rdy   = !pend_full_q;
  assign frame_strt = strt_q;
  assign underrun   = under_q;

endmodule

// File: tb/tb_pdm_encoder.sv
// Self-checking bench for pdm_encoder, run with a short frame so every corner fits in a few frames.
module tb_pdm_encoder;
  import pdm_pkg::*;

  localparam int FB     = 10;
  localparam int FULL   = 1 << FB;
  localparam int PART_M = FULL / 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        smpl_vld;
  logic        smpl_rdy;
  logic [15:0] lft_pcm;
  logic [15:0] rght_pcm;
  logic        lft_PDM;
  logic        rght_PDM;
  logic        frame_strt;
  logic        underrun;

  pdm_encoder #(.FRAME_BITS(FB)) dut (
    .clk       (clk),
    .rst       (rst),
    .smpl_vld  (smpl_vld),
    .smpl_rdy  (smpl_rdy),
    .lft_pcm   (lft_pcm),
    .rght_pcm  (rght_pcm),
    .lft_PDM   (lft_PDM),
    .rght_PDM  (rght_PDM),
    .frame_strt(frame_strt),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lft;
    int rght;
  } pair_t;

  typedef struct {
    int lft;
    int rght;
    int startCyc;
  } tx_t;

  typedef struct {
    int lft;
    int rght;
    int expL;
    int expR;
    int checkAlt;
  } vec_t;

  int    nChecks = 0;
  int    nFails  = 0;
  int    cyc     = 0;
  int    errRdy  = 0;
  int    errStrt = 0;
  int    errUnder = 0;
  tx_t   txQ[$];
  int    acceptCyc[$];
  int    mPendFull = 0;
  pair_t mPend;
  pair_t mActive;
  int    mCnt = 0;

  // Reference: over one frame a constant level yields min(level, full scale) ones.
  function automatic int refOnes(input int level);
    return (level > FULL) ? FULL : level;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    nChecks++;
    if (act < lo || act > hi) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic flushAggregates(input string name);
    checkOutput({name, "_rdy_cycles_wrong"}, errRdy, 0);
    checkOutput({name, "_strt_cycles_wrong"}, errStrt, 0);
    checkOutput({name, "_under_cycles_wrong"}, errUnder, 0);
    errRdy   = 0;
    errStrt  = 0;
    errUnder = 0;
  endtask

  task automatic queuePair(input int l, input int r, input int delay);
    tx_t t;
    t.lft      = l;
    t.rght     = r;
    t.startCyc = cyc + delay;
    txQ.push_back(t);
  endtask

  // Advance one clock, update the transaction-level model, compare control outputs, drive inputs.
  task automatic stepCycle();
    int wasVld, wasRst, wasBnd, expStrt, expUnder;
    wasVld = int'(smpl_vld);
    wasRst = int'(rst);
    wasBnd = (mCnt == FULL - 1) ? 1 : 0;
    @(posedge clk);
    #1;
    cyc++;
    if (wasRst != 0) begin
      mPendFull = 0;
      mActive   = '{lft: 0, rght: 0};
      mCnt      = 0;
      expStrt   = 0;
      expUnder  = 0;
    end else begin
      expStrt  = wasBnd;
      expUnder = (wasBnd != 0 && mPendFull == 0) ? 1 : 0;
      if (wasBnd != 0 && mPendFull != 0) begin
        mActive   = mPend;
        mPendFull = 0;
      end else if (wasVld != 0 && mPendFull == 0 && txQ.size() > 0) begin
        mPend     = '{lft: txQ[0].lft, rght: txQ[0].rght};
        void'(txQ.pop_front());
        mPendFull = 1;
        acceptCyc.push_back(cyc - 1);
      end
      mCnt = (mCnt + 1) % FULL;
    end
    if (int'(smpl_rdy) != ((mPendFull == 0) ? 1 : 0)) errRdy++;
    if (int'(frame_strt) != expStrt) errStrt++;
    if (int'(underrun) != expUnder) errUnder++;
    if (txQ.size() > 0 && cyc >= txQ[0].startCyc) begin
      smpl_vld = 1'b1;
      lft_pcm  = 16'(txQ[0].lft);
      rght_pcm = 16'(txQ[0].rght);
    end else begin
      smpl_vld = 1'b0;
      lft_pcm  = 16'($urandom);
      rght_pcm = 16'($urandom);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_rdy"}, int'(smpl_rdy), 1);
    checkOutput({name, "_lft_pdm"}, int'(lft_PDM), 0);
    checkOutput({name, "_rght_pdm"}, int'(rght_PDM), 0);
    checkOutput({name, "_frame_strt"}, int'(frame_strt), 0);
    checkOutput({name, "_underrun"}, int'(underrun), 0);
  endtask

  // From a cnt==0 cycle, the next frame_strt must come exactly one frame later.
  task automatic waitStrt(input string name, input int expUnder);
    int k, found, onesL, onesR;
    k = 0; found = 0; onesL = 0; onesR = 0;
    while (found == 0 && k < FULL + 8) begin
      stepCycle();
      k++;
      if (lft_PDM) onesL++;
      if (rght_PDM) onesR++;
      if (frame_strt) found = 1;
    end
    checkOutput({name, "_strt_found"}, found, 1);
    checkOutput({name, "_cycles_to_strt"}, k, FULL);
    checkOutput({name, "_ones_l"}, onesL, 0);
    checkOutput({name, "_ones_r"}, onesR, 0);
    checkOutput({name, "_underrun_at_strt"}, int'(underrun), expUnder);
    flushAggregates(name);
  endtask

  // Called in a frame_strt cycle; counts the frame's bits, which end with the next frame_strt.
  task automatic countFrame(input string name, output int onesL, output int onesR, output int altErr);
    int exL, exR, partL, partR, prevL, prevR;
    exL = refOnes(mActive.lft);
    exR = refOnes(mActive.rght);
    onesL = 0; onesR = 0; altErr = 0; partL = 0; partR = 0; prevL = -1; prevR = -1;
    for (int i = 1; i <= FULL; i++) begin
      stepCycle();
      if (lft_PDM) onesL++;
      if (rght_PDM) onesR++;
      if (i > 1 && int'(lft_PDM) == prevL) altErr++;
      if (i > 1 && int'(rght_PDM) == prevR) altErr++;
      prevL = int'(lft_PDM);
      prevR = int'(rght_PDM);
      if (i == PART_M) begin
        partL = onesL;
        partR = onesR;
      end
    end
    checkOutput({name, "_strt_at_frame_end"}, int'(frame_strt), 1);
    checkOutput({name, "_ones_l_model"}, onesL, exL);
    checkOutput({name, "_ones_r_model"}, onesR, exR);
    checkRange({name, "_partial_l"}, partL, (PART_M * exL) / FULL, (PART_M * exL + FULL - 1) / FULL);
    checkRange({name, "_partial_r"}, partR, (PART_M * exR) / FULL, (PART_M * exR + FULL - 1) / FULL);
    flushAggregates(name);
  endtask

  task automatic applyStimulus();
    vec_t tbl[5];
    int   l, r, alt;
    tbl[0] = '{lft: FULL / 2, rght: FULL / 2, expL: FULL / 2, expR: FULL / 2, checkAlt: 1};
    tbl[1] = '{lft: 1000, rght: 700, expL: 1000, expR: 700, checkAlt: 0};
    tbl[2] = '{lft: FULL, rght: 20000, expL: FULL, expR: FULL, checkAlt: 0};
    tbl[3] = '{lft: 0, rght: 0, expL: 0, expR: 0, checkAlt: 0};
    tbl[4] = '{lft: 65535, rght: 3, expL: FULL, expR: 3, checkAlt: 0};
    for (int t = 0; t < 5; t++) begin
      queuePair(tbl[t].lft, tbl[t].rght, 10);
      countFrame($sformatf("vec%0d_transition", t), l, r, alt);
      countFrame($sformatf("vec%0d_steady", t), l, r, alt);
      checkOutput($sformatf("vec%0d_ones_l", t), l, tbl[t].expL);
      checkOutput($sformatf("vec%0d_ones_r", t), r, tbl[t].expR);
      checkOutput($sformatf("vec%0d_hold_underrun", t), int'(underrun), 1);
      if (tbl[t].checkAlt != 0) checkOutput($sformatf("vec%0d_alternation_breaks", t), alt, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int l, r, alt, base, sStrt;
    rst      = 1'b1;
    smpl_vld = 1'b0;
    lft_pcm  = '0;
    rght_pcm = '0;
    mPend    = '{lft: 0, rght: 0};
    mActive  = '{lft: 0, rght: 0};

    repeat (3) stepCycle();
    rst = 1'b0;
    checkResetOutputs("reset");
    errRdy = 0; errStrt = 0; errUnder = 0;

    $display("[TB] idle frames after reset");
    waitStrt("idle0", 1);
    for (int f = 1; f < 3; f++) begin
      countFrame($sformatf("idle%0d", f), l, r, alt);
      checkOutput($sformatf("idle%0d_ones_l", f), l, 0);
      checkOutput($sformatf("idle%0d_underrun", f), int'(underrun), 1);
      checkOutput($sformatf("idle%0d_rdy", f), int'(smpl_rdy), 1);
    end

    $display("[TB] level table");
    applyStimulus();

    $display("[TB] back-to-back handshake");
    acceptCyc.delete();
    base = cyc;
    queuePair(300, 400, 20);
    queuePair(600, 100, 20);
    countFrame("b2b_x", l, r, alt);
    sStrt = cyc;
    checkOutput("b2b_accepts_in_frame", acceptCyc.size(), 1);
    checkOutput("b2b_first_accept_offset", (acceptCyc.size() > 0) ? acceptCyc[0] - base : -1, 20);
    checkOutput("b2b_rdy_after_boundary", int'(smpl_rdy), 1);
    countFrame("b2b_y", l, r, alt);
    checkOutput("b2b_first_ones_l", l, 300);
    checkOutput("b2b_first_ones_r", r, 400);
    checkOutput("b2b_second_accept_offset", (acceptCyc.size() > 1) ? acceptCyc[1] - sStrt : -1, 0);
    checkOutput("b2b_no_underrun", int'(underrun), 0);
    countFrame("b2b_z", l, r, alt);
    checkOutput("b2b_second_ones_l", l, 600);
    checkOutput("b2b_second_ones_r", r, 100);

    $display("[TB] pair presented in boundary cycle");
    acceptCyc.delete();
    base = cyc;
    queuePair(50, 900, FULL - 1);
    countFrame("bnd_w", l, r, alt);
    checkOutput("bnd_w_ones_l_old", l, 600);
    checkOutput("bnd_underrun", int'(underrun), 1);
    checkOutput("bnd_accept_offset", (acceptCyc.size() > 0) ? acceptCyc[0] - base : -1, FULL - 1);
    countFrame("bnd_v", l, r, alt);
    checkOutput("bnd_v_ones_l_old", l, 600);
    checkOutput("bnd_v_no_underrun", int'(underrun), 0);
    countFrame("bnd_u", l, r, alt);
    checkOutput("bnd_u_ones_l_new", l, 50);
    checkOutput("bnd_u_ones_r_new", r, 900);

    $display("[TB] reset mid-frame");
    queuePair(777, 777, 100);
    repeat (300) stepCycle();
    checkOutput("midrst_pending_full", int'(smpl_rdy), 0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkResetOutputs("midrst");
    errRdy = 0; errStrt = 0; errUnder = 0;
    waitStrt("midrst_first", 1);
    countFrame("midrst_next", l, r, alt);
    checkOutput("midrst_pair_lost_l", l, 0);
    checkOutput("midrst_pair_lost_r", r, 0);

    $display("[TB] randomized pairs");
    for (int k = 0; k < 4; k++) begin
      queuePair(int'($urandom_range(0, 1300)), int'($urandom_range(0, 1300)),
                int'($urandom_range(0, FULL - 1)));
      countFrame($sformatf("rand%0d", k), l, r, alt);
    end
    countFrame("rand_drain0", l, r, alt);
    countFrame("rand_drain1", l, r, alt);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
